hazard_control_unit: RTL
========================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports ID_rs1 / ID_rs2, input, 5 each, source registers of the instruction in ID.
REQ-004 SHALL have ports ID_use_rs1 / ID_use_rs2, input, 1 each, the ID instruction reads that source.
REQ-005 SHALL have ports ID_EX_rd (input, 5) and ID_EX_mem_read (input, 1), describing the instruction in EX.
REQ-006 SHALL have port EX_mispredict, input, 1, branch or jump in EX resolved against the fetched path.
REQ-007 SHALL have port ID_is_halt_ecall, input, 1, the ID instruction is ecall with x17 == 10 (value already forwarded).
REQ-008 SHALL have ports dmem_req and dmem_ready, input, 1 each, MEM-stage data-memory request and completion.
REQ-009 SHALL have ports PC_write and IF_ID_write, output, 1 each, enables for the PC and IF/ID registers.
REQ-010 SHALL have ports IF_ID_flush and ID_EX_flush, output, 1 each, insert a bubble into that register.
REQ-011 SHALL have port pipe_freeze, output, 1, holds the ID/EX, EX/MEM and MEM/WB registers.
REQ-012 SHALL have port is_halted, output, 1, the pipeline has drained after a halting ecall.
REQ-013 SHALL have port stall_cycles, output, 32, stall-cycle count (see Configuration).

Function
REQ-014 SHALL implement states RUN, DRAIN and HALTED in a registered state machine.
REQ-015 SHALL assert pipe_freeze combinationally when dmem_req && !dmem_ready in RUN or DRAIN. While frozen: PC_write=0, IF_ID_write=0, both flushes=0, and no state or counter advances except stall_cycles.
REQ-016 SHALL, when not frozen, in RUN, with EX_mispredict=1, drive IF_ID_flush=1, ID_EX_flush=1 and PC_write=1. Mispredict outranks load-use and halt-ecall in the same cycle, and the state stays RUN.
REQ-017 SHALL, when not frozen, in RUN, with no mispredict, detect load-use. Condition: ID_EX_mem_read && ID_EX_rd != 0 && ((ID_use_rs1 && ID_rs1 == ID_EX_rd) || (ID_use_rs2 && ID_rs2 == ID_EX_rd)). Response: PC_write=0, IF_ID_write=0, ID_EX_flush=1, for exactly one cycle per occurrence.
REQ-018 SHALL, in RUN, with no freeze, mispredict or load-use, and ID_is_halt_ecall=1: drive PC_write=0 and IF_ID_flush=1, load drain_cnt=3 and move to DRAIN next cycle.
REQ-019 SHALL, in DRAIN, drive PC_write=0, IF_ID_write=0 and IF_ID_flush=1. drain_cnt decrements on each unfrozen cycle; when it reaches 0 the next state is HALTED.
REQ-020 SHALL ignore EX_mispredict and load-use in DRAIN (no older branch can remain in EX).
REQ-021 SHALL, in HALTED, drive PC_write=0, IF_ID_write=0, pipe_freeze=1 and is_halted=1, and remain there until reset. dmem inputs are ignored in HALTED.
REQ-022 SHALL, in RUN with no hazard, drive PC_write=1, IF_ID_write=1, flushes=0, pipe_freeze=0 and is_halted=0.
REQ-023 SHALL treat register x0 as never hazardous.

Reset
REQ-024 SHALL, when reset=1 at a clock edge, set state=RUN, drain_cnt=0 and stall_cycles=0, overriding any in-progress DRAIN, HALTED or memory wait.
REQ-025 SHALL, after reset, present the RUN no-hazard outputs of REQ-022 until an input hazard occurs.

Configuration
REQ-026 SHALL, with macro HAZARD_STALL_COUNTER_EN defined, increment stall_cycles (wrapping at 2^32) on every cycle with PC_write=0 while state != HALTED.
REQ-027 SHALL, without HAZARD_STALL_COUNTER_EN, hold stall_cycles at constant 0 and contain no counter register.

Verification
REQ-028 SHALL verify load-use: ID_EX_mem_read=1, ID_EX_rd=5, ID_rs1=5, ID_use_rs1=1 -> one cycle of PC_write=0, IF_ID_write=0, ID_EX_flush=1; with ID_EX_rd=0 there is no stall.
REQ-029 SHALL verify priority: EX_mispredict=1 together with the load-use condition and ID_is_halt_ecall=1 -> IF_ID_flush=1, ID_EX_flush=1, PC_write=1, state stays RUN.
REQ-030 SHALL verify memory wait: dmem_req=1, dmem_ready=0 for 4 cycles, then ready -> pipe_freeze=1 for exactly those 4 cycles; stall_cycles +4 with HAZARD_STALL_COUNTER_EN defined.
REQ-031 SHALL verify halt: ID_is_halt_ecall=1 pulse -> DRAIN for 3 cycles, then is_halted=1 on the 4th edge; one injected 2-cycle memory wait during DRAIN delays is_halted by 2 cycles.
REQ-032 SHALL verify reset mid-drain: reset=1 during DRAIN -> RUN outputs, is_halted=0, stall_cycles=0 on the next cycle.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Hazard control unit for a 5-stage pipeline. It handles load-use stalls,
// mispredict flushes, data-memory wait freezes, and the drain after a halting ecall.
// Optional feature: define HAZARD_STALL_COUNTER_EN to enable the stall_cycles counter.
// Without that macro, stall_cycles is tied to 0.
module hazard_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic        ID_use_rs1,
    input  logic        ID_use_rs2,
    input  logic [4:0]  ID_EX_rd,
    input  logic        ID_EX_mem_read,
    input  logic        EX_mispredict,
    input  logic        ID_is_halt_ecall,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        PC_write,
    output logic        IF_ID_write,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic        pipe_freeze,
    output logic        is_halted,
    output logic [31:0] stall_cycles
);

    localparam int unsigned DRAIN_W     = 2;
    localparam int unsigned DRAIN_DEPTH = 3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t               state;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 mem_wait;
    logic                 load_use;

    // Hazard detection terms; x0 never produces a dependency
    always_comb begin
        mem_wait = dmem_req && !dmem_ready;
        load_use = ID_EX_mem_read && (ID_EX_rd != 5'd0) &&
                   ((ID_use_rs1 && (ID_rs1 == ID_EX_rd)) ||
                    (ID_use_rs2 && (ID_rs2 == ID_EX_rd)));
    end

    // Pipeline control decode from the current state and this cycle's hazards
    always_comb begin
        PC_write    = 1'b1;
        IF_ID_write = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        pipe_freeze = 1'b0;
        is_halted   = 1'b0;
        case (state)
            RUN: begin
                if (mem_wait) begin
                    pipe_freeze = 1'b1;
                    PC_write    = 1'b0;
                    IF_ID_write = 1'b0;
                end else if (EX_mispredict) begin
                    IF_ID_flush = 1'b1;
                    ID_EX_flush = 1'b1;
                end else if (load_use) begin
                    PC_write    = 1'b0;
                    IF_ID_write = 1'b0;
                    ID_EX_flush = 1'b1;
                end else if (ID_is_halt_ecall) begin
                    PC_write    = 1'b0;
                    IF_ID_flush = 1'b1;
                end
            end
            DRAIN: begin
                PC_write    = 1'b0;
                IF_ID_write = 1'b0;
                pipe_freeze = mem_wait;
                IF_ID_flush = !mem_wait;
            end
            HALTED: begin
                PC_write    = 1'b0;
                IF_ID_write = 1'b0;
                pipe_freeze = 1'b1;
                is_halted   = 1'b1;
            end
            default: ;
        endcase
    end

    // State machine and drain countdown; a memory wait holds everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (!mem_wait && !EX_mispredict && !load_use && ID_is_halt_ecall) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_W'(DRAIN_DEPTH);
                    end
                end
                DRAIN: begin
                    if (!mem_wait) begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                        if (drain_cnt <= DRAIN_W'(1)) begin
                            state <= HALTED;
                        end
                    end
                end
                HALTED: ;
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_STALL_COUNTER_EN
    logic [31:0] stall_q;

    // Count cycles where fetch is held, excluding the terminal halted state
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (!PC_write && (state != HALTED)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule
